// File: rtl/vip_dark_channel_3x3.sv
// vip_dark_channel_3x3: 3x3 minimum filter over min(R,G,B) with re-timed window-centre RGB.
// Fixed 3-clk latency, one pixel per clken, line buffers addressed by the input column.
module vip_dark_channel_3x3 #(
  parameter logic [10:0] IMG_HDISP = 11'd1024,
  parameter logic [10:0] IMG_VDISP = 11'd768
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Dark,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue
);
  localparam int W  = int'(IMG_HDISP);
  localparam int AW = $clog2(W);
  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction
  logic [2:0]    vsync_q, href_q, clken_q;
  logic [10:0]   x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0]   x1_q, y1_q, x2_q, y2_q;
  logic [7:0]    m1_q, m1_d, col_d, c0_q, c1_q, c2_q, dark_q, dark_d;
  logic [23:0]   rgb1_q, rgbc_q, rgb2_q, rgb_q, rgb_d;
  logic [7:0]    lb0_mem [W];
  logic [7:0]    lb1_mem [W];
  logic [23:0]   lbc_mem [W];
  logic          vs_rise, x_wrap;
  logic [AW-1:0] a;
  // Window holds column minima; out-of-frame taps are forced to FF so stale rows/columns never win.
  always_comb begin
    vs_rise = per_frame_vsync & ~vsync_q[0];
    x_wrap  = x_cnt_q == IMG_HDISP - 11'd1;
    x_cnt_d = vs_rise ? '0 : per_frame_clken ? (x_wrap ? '0 : x_cnt_q + 11'd1) : x_cnt_q;
    y_cnt_d = vs_rise ? '0 : (per_frame_clken && x_wrap) ?
              ((y_cnt_q == IMG_VDISP - 11'd1) ? '0 : y_cnt_q + 11'd1) : y_cnt_q;
    m1_d    = min2(min2(per_img_red, per_img_green), per_img_blue);
    a       = x1_q[AW-1:0];
    col_d   = min2(min2(y1_q < 11'd2 ? 8'hFF : lb0_mem[a], y1_q == 11'd0 ? 8'hFF : lb1_mem[a]), m1_q);
    dark_d  = min2(c2_q, min2(x2_q == 11'd0 ? 8'hFF : c1_q, x2_q < 11'd2 ? 8'hFF : c0_q));
    rgb_d   = (x2_q == 11'd0 || y2_q == 11'd0) ? '0 : rgb2_q;
  end
  always_ff @(posedge clk)
    if (clken_q[0]) begin
      lb0_mem[a] <= lb1_mem[a];
      lb1_mem[a] <= m1_q;
      lbc_mem[a] <= rgb1_q;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_q <= '0;
      href_q  <= '0;
      clken_q <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      m1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      dark_q  <= '0;
      rgb1_q  <= '0;
      rgbc_q  <= '0;
      rgb2_q  <= '0;
      rgb_q   <= '0;
    end else begin
      vsync_q <= {vsync_q[1:0], per_frame_vsync};
      href_q  <= {href_q[1:0], per_frame_href};
      clken_q <= {clken_q[1:0], per_frame_clken};
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      if (per_frame_clken) begin
        m1_q   <= m1_d;
        x1_q   <= x_cnt_q;
        y1_q   <= y_cnt_q;
        rgb1_q <= {per_img_red, per_img_green, per_img_blue};
      end
      // rgbc_q is the previous strobe's line-buffer read, i.e. pixel (x-1,y-1) by stage 3
      if (clken_q[0]) begin
        c0_q   <= c1_q;
        c1_q   <= c2_q;
        c2_q   <= col_d;
        x2_q   <= x1_q;
        y2_q   <= y1_q;
        rgbc_q <= lbc_mem[a];
        rgb2_q <= rgbc_q;
      end
      if (clken_q[1]) begin
        dark_q <= dark_d;
        rgb_q  <= rgb_d;
      end
    end
  assign post_frame_vsync = vsync_q[2];
  assign post_frame_href  = href_q[2];
  assign post_frame_clken = clken_q[2];
  assign post_img_Dark    = dark_q;
  assign {post_img_red, post_img_green, post_img_blue} = rgb_q;
endmodule
